// File: rtl/mac_rx_ingest.sv
// mac_rx_ingest
// Receive ingest stage behind the tri-mode MAC RX FIFO. It pulls 32-bit words
// from the MAC and frames packets on SOP/EOP. It stores complete packets in a
// circular word buffer and queues one length descriptor per committed packet.
// The word-read port only ever reaches committed packets.
//
// Ports:
//   mac_clk_i, mac_rst_i        clock, asynchronous active-high reset
//   mac_rxd_i, mac_ben_i        data word and EOP byte-enable code (00=4..11=1)
//   mac_rxda_i                  MAC has data available
//   mac_rxsop_i, mac_rxeop_i    framing, qualified by mac_rxdv_i
//   mac_rxdv_i                  word valid this cycle
//   mac_rxrqrd_o                read request to the MAC
//   pkt_avail_o, pkt_len_o      head packet present and its byte length
//   rd_en_i                     pop one word of the head packet
//   rd_data_o, rd_valid_o,      read word, valid and last-word flag
//   rd_last_o                   (one cycle after rd_en_i)
//   pkt_drop_o, drop_cnt_o      drop pulse and saturating drop count
module mac_rx_ingest #(
    parameter int BUF_AW        = 10,
    parameter int DESC_AW       = 3,
    parameter int MAX_PKT_WORDS = 512
) (
    input  logic        mac_clk_i,
    input  logic        mac_rst_i,
    input  logic [31:0] mac_rxd_i,
    input  logic [1:0]  mac_ben_i,
    input  logic        mac_rxda_i,
    input  logic        mac_rxsop_i,
    input  logic        mac_rxeop_i,
    input  logic        mac_rxdv_i,
    output logic        mac_rxrqrd_o,
    output logic        pkt_avail_o,
    output logic [15:0] pkt_len_o,
    input  logic        rd_en_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_last_o,
    output logic        pkt_drop_o,
    output logic [15:0] drop_cnt_o
);
    localparam int BUF_DEPTH  = 1 << BUF_AW;
    localparam int DESC_DEPTH = 1 << DESC_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Valid byte count of the EOP word from the MAC byte-enable code.
    function automatic logic [2:0] ben_bytes(input logic [1:0] ben);
        return 3'd4 - {1'b0, ben};
    endfunction

    state_t              r_state;
    logic [BUF_AW:0]     r_wr_ptr, r_commit_ptr, r_pkt_start, r_rd_ptr;
    logic [15:0]         r_word_cnt, r_rd_cnt, r_drop_cnt;
    logic [DESC_AW:0]    r_desc_wr, r_desc_rd;
    logic [31:0]         r_buf [BUF_DEPTH];
    logic [15:0]         r_desc_len [DESC_DEPTH];
    logic [31:0]         r_rd_data;
    logic                r_rd_valid, r_rd_last, r_drop;

    state_t              w_nxt_state;
    logic [BUF_AW:0]     w_nxt_wr_ptr, w_nxt_commit_ptr, w_nxt_pkt_start;
    logic [15:0]         w_nxt_word_cnt;
    logic                w_we, w_push, w_fresh;
    logic [BUF_AW-1:0]   w_waddr;
    logic [15:0]         w_push_len;
    logic [1:0]          w_drop_n;
    logic [16:0]         w_drop_sum;

    // Occupancy is measured against the speculative write pointer so that
    // words of a packet still being received also hold off the MAC.
    logic [BUF_AW:0]     w_used, w_free, w_base_used;
    logic                w_full, w_base_full, w_desc_full, w_desc_empty;
    logic [15:0]         w_head_len, w_head_words;
    logic                w_rd_fire, w_rd_is_last;

    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_free       = (BUF_AW+1)'(BUF_DEPTH) - w_used;
    assign w_full       = w_used[BUF_AW];
    // A fresh SOP always restarts at the commit pointer, so its space check
    // must ignore any aborted partial packet.
    assign w_base_used  = r_commit_ptr - r_rd_ptr;
    assign w_base_full  = w_base_used[BUF_AW];
    assign w_desc_empty = (r_desc_wr == r_desc_rd);
    assign w_desc_full  = (r_desc_wr[DESC_AW] != r_desc_rd[DESC_AW]) &&
                          (r_desc_wr[DESC_AW-1:0] == r_desc_rd[DESC_AW-1:0]);
    assign w_head_len   = r_desc_len[r_desc_rd[DESC_AW-1:0]];
    assign w_head_words = (w_head_len + 16'd3) >> 2;
    assign w_rd_fire    = rd_en_i && !w_desc_empty;
    assign w_rd_is_last = ((r_rd_cnt + 16'd1) == w_head_words);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + {15'd0, w_drop_n};

    assign mac_rxrqrd_o = !mac_rst_i && mac_rxda_i && (w_free >= (BUF_AW+1)'(3));
    assign pkt_avail_o  = !w_desc_empty;
    assign pkt_len_o    = w_desc_empty ? 16'd0 : w_head_len;
    assign rd_data_o    = r_rd_data;
    assign rd_valid_o   = r_rd_valid;
    assign rd_last_o    = r_rd_last;
    assign pkt_drop_o   = r_drop;
    assign drop_cnt_o   = r_drop_cnt;

    // Ingest FSM next-state, buffer write, commit and drop decisions.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_wr_ptr     = r_wr_ptr;
        w_nxt_commit_ptr = r_commit_ptr;
        w_nxt_pkt_start  = r_pkt_start;
        w_nxt_word_cnt   = r_word_cnt;
        w_we             = 1'b0;
        w_waddr          = r_wr_ptr[BUF_AW-1:0];
        w_push           = 1'b0;
        w_push_len       = 16'd0;
        w_drop_n         = 2'd0;
        w_fresh          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mac_rxdv_i && mac_rxsop_i) begin
                    w_fresh = 1'b1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (!mac_rxdv_i) begin
                    w_nxt_state = ST_RECV;
                end else if (mac_rxsop_i) begin
                    // SOP without EOP: abandon the partial packet and restart.
                    w_drop_n     = 2'd1;
                    w_nxt_wr_ptr = r_pkt_start;
                    w_fresh      = 1'b1;
                end else if (w_full || (r_word_cnt >= 16'(MAX_PKT_WORDS)) ||
                             (mac_rxeop_i && w_desc_full)) begin
                    w_drop_n     = 2'd1;
                    w_nxt_wr_ptr = r_pkt_start;
                    w_nxt_state  = mac_rxeop_i ? ST_IDLE : ST_DROP;
                end else begin
                    w_we           = 1'b1;
                    w_nxt_wr_ptr   = r_wr_ptr + (BUF_AW+1)'(1);
                    w_nxt_word_cnt = r_word_cnt + 16'd1;
                    if (mac_rxeop_i) begin
                        w_push           = 1'b1;
                        w_push_len       = {r_word_cnt[13:0], 2'b00} +
                                           {13'd0, ben_bytes(mac_ben_i)};
                        w_nxt_commit_ptr = r_wr_ptr + (BUF_AW+1)'(1);
                        w_nxt_state      = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_RECV;
                    end
                end
            end
            ST_DROP: begin
                if (mac_rxdv_i && mac_rxeop_i) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_DROP;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        if (w_fresh) begin
            w_nxt_pkt_start = r_commit_ptr;
            w_nxt_word_cnt  = 16'd1;
            if (w_base_full || (mac_rxeop_i && w_desc_full)) begin
                w_drop_n     = w_drop_n + 2'd1;
                w_nxt_wr_ptr = r_commit_ptr;
                w_nxt_state  = mac_rxeop_i ? ST_IDLE : ST_DROP;
            end else begin
                w_we         = 1'b1;
                w_waddr      = r_commit_ptr[BUF_AW-1:0];
                w_nxt_wr_ptr = r_commit_ptr + (BUF_AW+1)'(1);
                if (mac_rxeop_i) begin
                    w_push           = 1'b1;
                    w_push_len       = {13'd0, ben_bytes(mac_ben_i)};
                    w_nxt_commit_ptr = r_commit_ptr + (BUF_AW+1)'(1);
                    w_nxt_state      = ST_IDLE;
                end else begin
                    w_nxt_state = ST_RECV;
                end
            end
        end else begin
            w_nxt_pkt_start = r_pkt_start;
        end
    end

    // Ingest state, write-side pointers, descriptor push and drop accounting.
    always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
        if (mac_rst_i) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_start  <= '0;
            r_word_cnt   <= 16'd0;
            r_desc_wr    <= '0;
            r_drop       <= 1'b0;
            r_drop_cnt   <= 16'd0;
        end else begin
            r_state      <= w_nxt_state;
            r_wr_ptr     <= w_nxt_wr_ptr;
            r_commit_ptr <= w_nxt_commit_ptr;
            r_pkt_start  <= w_nxt_pkt_start;
            r_word_cnt   <= w_nxt_word_cnt;
            r_drop       <= (w_drop_n != 2'd0);
            r_drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_push) begin
                r_desc_wr <= r_desc_wr + (DESC_AW+1)'(1);
            end
        end
    end

    // Word buffer storage.
    always_ff @(posedge mac_clk_i) begin
        if (w_we) begin
            r_buf[w_waddr] <= mac_rxd_i;
        end
    end

    // Descriptor length storage.
    always_ff @(posedge mac_clk_i) begin
        if (w_push) begin
            r_desc_len[r_desc_wr[DESC_AW-1:0]] <= w_push_len;
        end
    end

    // Read port: one registered word per accepted rd_en_i, descriptor pop on last.
    always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
        if (mac_rst_i) begin
            r_rd_ptr   <= '0;
            r_rd_cnt   <= 16'd0;
            r_desc_rd  <= '0;
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= r_buf[r_rd_ptr[BUF_AW-1:0]];
                r_rd_last <= w_rd_is_last;
                r_rd_ptr  <= r_rd_ptr + (BUF_AW+1)'(1);
                if (w_rd_is_last) begin
                    r_rd_cnt  <= 16'd0;
                    r_desc_rd <= r_desc_rd + (DESC_AW+1)'(1);
                end else begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end else begin
                r_rd_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_rx_ingest.sv
// Testbench for mac_rx_ingest: a default-size instance (u_main) and a 16-word
// buffer instance (u_small) for the backpressure/full case. Read words are
// scoreboarded: each rd_en_i pushes the expected {last, data} and a monitor
// pops and compares whenever rd_valid_o is seen.
module tb_mac_rx_ingest;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] m_rxd, m_rd_data, s_rxd, s_rd_data;
    logic [1:0]  m_ben, s_ben;
    logic        m_rxda, m_sop, m_eop, m_dv, m_rd_en, m_rqrd, m_avail, m_rd_valid, m_rd_last, m_drop;
    logic        s_rxda, s_sop, s_eop, s_dv, s_rd_en, s_rqrd, s_avail, s_rd_valid, s_rd_last, s_drop;
    logic [15:0] m_len, m_drop_cnt, s_len, s_drop_cnt;

    mac_rx_ingest u_main (
        .mac_clk_i(clk), .mac_rst_i(rst), .mac_rxd_i(m_rxd), .mac_ben_i(m_ben),
        .mac_rxda_i(m_rxda), .mac_rxsop_i(m_sop), .mac_rxeop_i(m_eop), .mac_rxdv_i(m_dv),
        .mac_rxrqrd_o(m_rqrd), .pkt_avail_o(m_avail), .pkt_len_o(m_len), .rd_en_i(m_rd_en),
        .rd_data_o(m_rd_data), .rd_valid_o(m_rd_valid), .rd_last_o(m_rd_last),
        .pkt_drop_o(m_drop), .drop_cnt_o(m_drop_cnt)
    );

    mac_rx_ingest #(.BUF_AW(4), .DESC_AW(3), .MAX_PKT_WORDS(512)) u_small (
        .mac_clk_i(clk), .mac_rst_i(rst), .mac_rxd_i(s_rxd), .mac_ben_i(s_ben),
        .mac_rxda_i(s_rxda), .mac_rxsop_i(s_sop), .mac_rxeop_i(s_eop), .mac_rxdv_i(s_dv),
        .mac_rxrqrd_o(s_rqrd), .pkt_avail_o(s_avail), .pkt_len_o(s_len), .rd_en_i(s_rd_en),
        .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid), .rd_last_o(s_rd_last),
        .pkt_drop_o(s_drop), .drop_cnt_o(s_drop_cnt)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int m_drop_pulses = 0;
    logic [32:0] m_q[$];
    logic [32:0] s_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitors: compare every presented read word with the queue head.
    always @(negedge clk) begin
        if (m_rd_valid === 1'b1) begin
            if (m_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL m_unexpected_read: got 0x%0h, expected no read", m_rd_data);
            end else begin
                check("m_rd_word", {31'd0, m_rd_last, m_rd_data}, {31'd0, m_q.pop_front()});
            end
        end
        if (s_rd_valid === 1'b1) begin
            if (s_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL s_unexpected_read: got 0x%0h, expected no read", s_rd_data);
            end else begin
                check("s_rd_word", {31'd0, s_rd_last, s_rd_data}, {31'd0, s_q.pop_front()});
            end
        end
        if (m_drop === 1'b1) m_drop_pulses++;
    end

    task automatic send(input bit sm, input logic [31:0] d, input logic sop,
                        input logic eop, input logic [1:0] ben);
        if (sm) begin s_rxd = d; s_sop = sop; s_eop = eop; s_ben = ben; s_dv = 1'b1; end
        else    begin m_rxd = d; m_sop = sop; m_eop = eop; m_ben = ben; m_dv = 1'b1; end
        @(posedge clk); #1;
        if (sm) s_dv = 1'b0; else m_dv = 1'b0;
    endtask

    task automatic rd(input bit sm, input logic [31:0] d, input logic last);
        if (sm) begin s_q.push_back({last, d}); s_rd_en = 1'b1; end
        else    begin m_q.push_back({last, d}); m_rd_en = 1'b1; end
        @(posedge clk); #1;
        if (sm) s_rd_en = 1'b0; else m_rd_en = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        m_rxd = 32'd0; m_ben = 2'd0; m_rxda = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_dv = 1'b0; m_rd_en = 1'b0;
        s_rxd = 32'd0; s_ben = 2'd0; s_rxda = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_dv = 1'b0; s_rd_en = 1'b0;
        #12;
        check("reset_avail", {63'd0, m_avail}, 64'd0);
        check("reset_len", {48'd0, m_len}, 64'd0);
        check("reset_rd_valid", {63'd0, m_rd_valid}, 64'd0);
        check("reset_drop_cnt", {48'd0, m_drop_cnt}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        m_rxda = 1'b1;
        #1;
        check("rqrd_empty", {63'd0, m_rqrd}, 64'd1);

        // Single 5-word packet, ben=10 on EOP -> 18 bytes.
        for (int i = 1; i <= 5; i++) send(1'b0, 32'h11111111 * i, i == 1, i == 5, 2'b10);
        check("t1_avail", {63'd0, m_avail}, 64'd1);
        check("t1_len", {48'd0, m_len}, 64'd18);
        for (int i = 1; i <= 5; i++) rd(1'b0, 32'h11111111 * i, i == 5);
        check("t1_avail_after", {63'd0, m_avail}, 64'd0);
        check("t1_len_after", {48'd0, m_len}, 64'd0);
        m_rd_en = 1'b1;              // ignored: nothing committed
        @(posedge clk); #1;
        m_rd_en = 1'b0;
        @(posedge clk); #1;

        // Single-word packet, ben=11 -> 1 byte.
        send(1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 2'b11);
        check("t2_avail", {63'd0, m_avail}, 64'd1);
        check("t2_len", {48'd0, m_len}, 64'd1);
        rd(1'b0, 32'hA5A5A5A5, 1'b1);
        check("t2_avail_after", {63'd0, m_avail}, 64'd0);

        // SOP mid-packet aborts the first 3 words.
        send(1'b0, 32'h100, 1'b1, 1'b0, 2'b00);
        send(1'b0, 32'h101, 1'b0, 1'b0, 2'b00);
        send(1'b0, 32'h102, 1'b0, 1'b0, 2'b00);
        send(1'b0, 32'h200, 1'b1, 1'b0, 2'b00);
        check("t3_drop_pulse", {63'd0, m_drop}, 64'd1);
        send(1'b0, 32'h201, 1'b0, 1'b1, 2'b00);
        check("t3_drop_pulse_end", {63'd0, m_drop}, 64'd0);
        check("t3_drop_cnt", {48'd0, m_drop_cnt}, 64'd1);
        check("t3_len", {48'd0, m_len}, 64'd8);
        rd(1'b0, 32'h200, 1'b0);
        rd(1'b0, 32'h201, 1'b1);
        check("t3_avail_after", {63'd0, m_avail}, 64'd0);

        // Oversize: 513 words, EOP on the last one.
        p0 = m_drop_pulses;
        for (int i = 0; i <= 512; i++) send(1'b0, 32'h5000 + i, i == 0, i == 512, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_drop_pulses", 64'(m_drop_pulses - p0), 64'd1);
        check("t4_avail", {63'd0, m_avail}, 64'd0);
        check("t4_drop_cnt", {48'd0, m_drop_cnt}, 64'd2);
        for (int i = 0; i < 4; i++) send(1'b0, 32'h300 + i, i == 0, i == 3, 2'b00);
        check("t4_len", {48'd0, m_len}, 64'd16);
        for (int i = 0; i < 4; i++) rd(1'b0, 32'h300 + i, i == 3);

        // Backpressure and full on the 16-word instance, never read during ingest.
        s_rxda = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 32'hA0 + i, i == 0, i == 5, 2'b00);
        for (int i = 0; i < 6; i++) send(1'b1, 32'hB0 + i, i == 0, i == 5, 2'b11);
        check("t5_rqrd_free4", {63'd0, s_rqrd}, 64'd1);
        send(1'b1, 32'hC0, 1'b1, 1'b0, 2'b00);
        check("t5_rqrd_free3", {63'd0, s_rqrd}, 64'd1);
        send(1'b1, 32'hC1, 1'b0, 1'b0, 2'b00);
        check("t5_rqrd_free2", {63'd0, s_rqrd}, 64'd0);
        send(1'b1, 32'hC2, 1'b0, 1'b0, 2'b00);
        send(1'b1, 32'hC3, 1'b0, 1'b0, 2'b00);
        check("t5_rqrd_full", {63'd0, s_rqrd}, 64'd0);
        send(1'b1, 32'hC4, 1'b0, 1'b0, 2'b00);
        check("t5_drop_pulse", {63'd0, s_drop}, 64'd1);
        for (int i = 5; i < 8; i++) send(1'b1, 32'hC0 + i, 1'b0, i == 7, 2'b00);
        check("t5_rqrd_after", {63'd0, s_rqrd}, 64'd1);
        check("t5_drop_cnt", {48'd0, s_drop_cnt}, 64'd1);
        check("t5_avail", {63'd0, s_avail}, 64'd1);
        check("t5_len_a", {48'd0, s_len}, 64'd24);
        for (int i = 0; i < 6; i++) rd(1'b1, 32'hA0 + i, i == 5);
        check("t5_len_b", {48'd0, s_len}, 64'd21);
        for (int i = 0; i < 6; i++) rd(1'b1, 32'hB0 + i, i == 5);
        check("t5_avail_after", {63'd0, s_avail}, 64'd0);

        // Reset in the middle of a packet.
        send(1'b0, 32'hD0, 1'b1, 1'b0, 2'b00);
        send(1'b0, 32'hD1, 1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        check("t6_rqrd", {63'd0, m_rqrd}, 64'd0);
        check("t6_rd_data", {32'd0, m_rd_data}, 64'd0);
        check("t6_drop_cnt", {48'd0, m_drop_cnt}, 64'd0);
        check("t6_outputs", {59'd0, m_avail, m_rd_valid, m_rd_last, m_drop, |m_len}, 64'd0);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 32'hC0, 1'b1, 1'b0, 2'b01);
        send(1'b0, 32'hC1, 1'b0, 1'b0, 2'b01);
        send(1'b0, 32'hC2, 1'b0, 1'b1, 2'b01);
        check("t6_len", {48'd0, m_len}, 64'd11);
        for (int i = 0; i < 3; i++) rd(1'b0, 32'hC0 + i, i == 2);
        check("t6_drop_cnt_after", {48'd0, m_drop_cnt}, 64'd0);
        check("t6_avail_after", {63'd0, m_avail}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("m_queue_drained", 64'(m_q.size()), 64'd0);
        check("s_queue_drained", 64'(s_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
